// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Parity bit over a zero-extended data word; zero padding does not change XOR.
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
    if (mode == PAR_ODD) begin
      return ~(^data);
    end else begin
      return ^data;
    end
  endfunction

  // Modes 00 and 11 both mean "no parity bit in the frame".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the transmitter; extra pointer MSB separates full from empty.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign level     = wr_ptr_r - rd_ptr_r;
  assign full      = (level == (AW+1)'(DEPTH));
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

  // Read/write pointers wrap modulo DEPTH with one extra lap bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo_core.sv
// Buffered UART transmitter: FIFO front end, frame FSM and baud divider.
module uart_tx_fifo_core
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int DIV_W      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [1:0]                  parity_mode,
  input  logic                        two_stop,
  input  logic [DATA_BITS-1:0]        s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int IW = $clog2(DATA_BITS);

  tx_state_e            state_r;
  tx_state_e            state_s;
  logic                 pop_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [DATA_BITS-1:0] fifo_rdata_s;
  logic [DATA_BITS-1:0] data_r;
  logic [DIV_W-1:0]     div_r;
  logic [DIV_W-1:0]     baud_cnt_r;
  logic [1:0]           par_mode_r;
  logic                 two_stop_r;
  logic [IW-1:0]        bit_idx_r;
  logic                 stop_idx_r;
  logic                 bit_done_s;
  logic                 tx_s;
  logic                 tx_r;
  logic                 busy_r;

  assign s_ready    = !fifo_full_s;
  assign bit_done_s = (baud_cnt_r == '0);
  assign tx         = tx_r;
  assign busy       = busy_r;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid),
    .pop   (pop_s),
    .wdata (s_data),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a pop happens whenever a new frame is launched.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (ena && !fifo_empty_s) begin
          state_s = START;
          pop_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_done_s && (bit_idx_r == IW'(DATA_BITS-1))) begin
          if (parity_enabled(par_mode_r)) begin
            state_s = PARITY;
          end else begin
            state_s = STOP;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (bit_done_s) begin
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (bit_done_s && (stop_idx_r == two_stop_r)) begin
          if (ena && !fifo_empty_s) begin
            state_s = START;
            pop_s   = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Serial line value for the current state, registered below.
  always_comb begin
    tx_s = 1'b1;
    case (state_r)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = data_r[bit_idx_r];
      PARITY:  tx_s = parity_bit(9'(data_r), par_mode_r);
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // Frame datapath: latch config on pop, baud countdown and bit/stop indices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r     <= '0;
      div_r      <= '0;
      baud_cnt_r <= '0;
      par_mode_r <= PAR_NONE;
      two_stop_r <= 1'b0;
      bit_idx_r  <= '0;
      stop_idx_r <= 1'b0;
    end else if (pop_s) begin
      data_r     <= fifo_rdata_s;
      div_r      <= baud_div;
      baud_cnt_r <= baud_div;
      par_mode_r <= parity_mode;
      two_stop_r <= two_stop;
      bit_idx_r  <= '0;
      stop_idx_r <= 1'b0;
    end else if (state_r != IDLE) begin
      if (bit_done_s) begin
        baud_cnt_r <= div_r;
        if (state_r == DATA) begin
          bit_idx_r <= bit_idx_r + IW'(1);
        end
        if (state_r == STOP) begin
          stop_idx_r <= 1'b1;
        end
      end else begin
        baud_cnt_r <= baud_cnt_r - DIV_W'(1);
      end
    end
  end

  // Registered line and busy outputs; tx idles high out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      tx_r   <= tx_s;
      busy_r <= (state_r != IDLE) || !fifo_empty_s;
    end
  end

endmodule
